addsub_share_scheduler: RTL and testbench

//  Shares one combinational 4-bit add/sub unit (S,C = A + (B^{4{K}}) + K) between two requesters.

---
 rtl/addsub_share_scheduler_pkg.sv | 27 ++
 rtl/addsub_share_scheduler_checker.sv | 32 +++
 rtl/rr_arbiter_2.sv | 34 +++
 rtl/addsub_share_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_addsub_share_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_share_scheduler_pkg.sv
// Shared definitions for the nibble-serial add/sub scheduler.
package addsub_share_scheduler_pkg;

  // Width of the external add/sub unit; operands are two nibbles wide.
  localparam int NIB_W = 4;
  // Number of requesters and width of the requester id.
  localparam int REQ_N = 2;
  localparam int ID_W  = 1;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_INC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // High-nibble B operand: inverted for subtraction. The +1 of the
  // two's complement enters through the low pass carry-in instead.
  function automatic logic [NIB_W-1:0] hi_operand(input logic [NIB_W-1:0] b,
                                                  input logic             k);
    return b ^ {NIB_W{k}};
  endfunction

endpackage

// File: rtl/addsub_share_scheduler_checker.sv
// Protocol properties for addsub_share_scheduler, observed on its ports.
module addsub_share_scheduler_checker #(
  parameter int NIB = 4
) (
  input logic           clk,
  input logic           rst,
  input logic           gnt0,
  input logic           gnt1,
  input logic           done0,
  input logic           done1,
  input logic           busy,
  input logic [NIB-1:0] alu_a,
  input logic [NIB-1:0] alu_b,
  input logic           alu_k
);

  // At most one requester is accepted per cycle
  a_one_gnt: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));

  // At most one completion per cycle
  a_one_done: assert property (@(posedge clk) disable iff (rst) !(done0 && done1));

  // The accept cycle precedes busy, and busy follows right after it
  a_gnt_idle: assert property (@(posedge clk) disable iff (rst) (gnt0 || gnt1) |-> !busy);
  a_gnt_busy: assert property (@(posedge clk) disable iff (rst) (gnt0 || gnt1) |=> busy);

  // Completion happens inside the busy window with the unit released
  a_done_busy: assert property (@(posedge clk) disable iff (rst) (done0 || done1) |-> busy);
  a_done_alu: assert property (@(posedge clk) disable iff (rst)
    (done0 || done1) |-> ((alu_a == {NIB{1'b0}}) && (alu_b == {NIB{1'b0}}) && !alu_k));

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. The pointer remembers the last served
// requester; on a tie the other one wins. A lone request always wins.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // 1 = requester 1 was served last (so requester 0 wins the first tie)
  logic last_r;

  // Grant selection from current requests and the last-served pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves only when the grant is actually consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (adv && (gnt != 2'b00)) begin
      last_r <= gnt[1];
    end
  end

endmodule

// File: rtl/addsub_share_scheduler.sv
// Two-requester scheduler that builds 8-bit add/sub from nibble passes
// through one shared external 4-bit add/sub unit (S,C = A + (B^K) + K).
module addsub_share_scheduler
  import addsub_share_scheduler_pkg::*;
#(
  parameter int NIB      = NIB_W,
  parameter bit SKIP_INC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2*NIB-1:0] op_a0,
  input  logic [2*NIB-1:0] op_b0,
  input  logic             op_k0,
  input  logic [2*NIB-1:0] op_a1,
  input  logic [2*NIB-1:0] op_b1,
  input  logic             op_k1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [2*NIB-1:0] res,
  output logic             res_c,
  output logic             busy,
  output logic [NIB-1:0]   alu_a,
  output logic [NIB-1:0]   alu_b,
  output logic             alu_k,
  input  logic [NIB-1:0]   alu_s,
  input  logic             alu_c
);

  localparam int W = 2 * NIB;

  state_t         state_r;
  logic [NIB-1:0] a_hi_r;     // A[7:4] of the accepted operation
  logic [NIB-1:0] b_hi_r;     // B[7:4], already inverted for subtraction
  id_t            id_r;       // requester being served
  logic [NIB-1:0] s_lo_r;
  logic [NIB-1:0] s_hi_r;
  logic           c0_r;       // low pass carry, pending into the high nibble
  logic           c1_r;       // high pass carry
  logic           c2_r;       // carry from adding c0 to the high nibble

  logic [1:0]     arb_req_s;
  logic [1:0]     arb_gnt_s;
  logic           adv_s;
  logic [W-1:0]   sel_a_s;
  logic [W-1:0]   sel_b_s;
  logic           sel_k_s;
  id_t            sel_id_s;

  assign arb_req_s = {req1, req0};
  // Requests are only looked at while idle; anything raised while busy
  // is simply not seen until the FSM is back in IDLE.
  assign adv_s     = (state_r == ST_IDLE) && (arb_gnt_s != 2'b00);

  rr_arbiter_2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req_s),
    .adv (adv_s),
    .gnt (arb_gnt_s)
  );

  // Operand mux for the requester the arbiter picked this cycle
  always_comb begin
    sel_a_s  = op_a0;
    sel_b_s  = op_b0;
    sel_k_s  = op_k0;
    sel_id_s = 1'b0;
    if (arb_gnt_s[1]) begin
      sel_a_s  = op_a1;
      sel_b_s  = op_b1;
      sel_k_s  = op_k1;
      sel_id_s = 1'b1;
    end else begin
      sel_a_s  = op_a0;
      sel_b_s  = op_b0;
      sel_k_s  = op_k0;
      sel_id_s = 1'b0;
    end
  end

  // Sequencer: accept, low pass, high pass, optional carry pass, result.
  // Unit drives are registered and loaded on entry to the state using them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_hi_r  <= {NIB{1'b0}};
      b_hi_r  <= {NIB{1'b0}};
      id_r    <= 1'b0;
      s_lo_r  <= {NIB{1'b0}};
      s_hi_r  <= {NIB{1'b0}};
      c0_r    <= 1'b0;
      c1_r    <= 1'b0;
      c2_r    <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      res     <= {W{1'b0}};
      res_c   <= 1'b0;
      busy    <= 1'b0;
      alu_a   <= {NIB{1'b0}};
      alu_b   <= {NIB{1'b0}};
      alu_k   <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          if (adv_s) begin
            // The low nibbles go straight into the unit drive registers,
            // which double as their latch; only the high nibbles are kept.
            a_hi_r  <= sel_a_s[W-1:NIB];
            b_hi_r  <= hi_operand(sel_b_s[W-1:NIB], sel_k_s);
            id_r    <= sel_id_s;
            gnt0    <= arb_gnt_s[0];
            gnt1    <= arb_gnt_s[1];
            alu_a   <= sel_a_s[NIB-1:0];
            alu_b   <= sel_b_s[NIB-1:0];
            alu_k   <= sel_k_s;
            state_r <= ST_LO;
          end else begin
            alu_a <= {NIB{1'b0}};
            alu_b <= {NIB{1'b0}};
            alu_k <= 1'b0;
          end
        end
        ST_LO: begin
          s_lo_r  <= alu_s;
          c0_r    <= alu_c;
          busy    <= 1'b1;
          alu_a   <= a_hi_r;
          alu_b   <= b_hi_r;
          alu_k   <= 1'b0;
          state_r <= ST_HI;
        end
        ST_HI: begin
          s_hi_r <= alu_s;
          c1_r   <= alu_c;
          c2_r   <= 1'b0;
          if (!SKIP_INC || c0_r) begin
            // Add c0 into the high nibble. With c0=1 the unit sees
            // s_hi + (F^F) + 1; with c0=0 (constant-latency mode) it sees
            // s_hi + 0 + 0, leaving the nibble and carry untouched.
            alu_a   <= alu_s;
            alu_b   <= {NIB{c0_r}};
            alu_k   <= c0_r;
            state_r <= ST_INC;
          end else begin
            alu_a   <= {NIB{1'b0}};
            alu_b   <= {NIB{1'b0}};
            alu_k   <= 1'b0;
            state_r <= ST_DONE;
          end
        end
        ST_INC: begin
          s_hi_r  <= alu_s;
          c2_r    <= alu_c;
          alu_a   <= {NIB{1'b0}};
          alu_b   <= {NIB{1'b0}};
          alu_k   <= 1'b0;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          // c1 and c2 are exclusive: the high nibble can only overflow once
          res     <= {s_hi_r, s_lo_r};
          res_c   <= c1_r | c2_r;
          done0   <= (id_r == 1'b0);
          done1   <= (id_r == 1'b1);
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          alu_a   <= {NIB{1'b0}};
          alu_b   <= {NIB{1'b0}};
          alu_k   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_share_scheduler.sv
// Directed bench for addsub_share_scheduler with a behavioural 4-bit unit.
module tb_addsub_share_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0, req1, op_k0, op_k1;
  logic [7:0] op_a0, op_b0, op_a1, op_b1;
  logic       gnt0, gnt1, done0, done1, res_c, busy, alu_k, alu_c;
  logic [7:0] res;
  logic [3:0] alu_a, alu_b, alu_s;

  logic       c_req0, c_req1, c_op_k0, c_op_k1;
  logic [7:0] c_op_a0, c_op_b0, c_op_a1, c_op_b1;
  logic       c_gnt0, c_gnt1, c_done0, c_done1, c_res_c, c_busy, c_alu_k, c_alu_c;
  logic [7:0] c_res;
  logic [3:0] c_alu_a, c_alu_b, c_alu_s;

  int checks = 0;
  int errors = 0;

  // External 4-bit add/sub units: S,C = A + (B ^ {4{K}}) + K
  assign {alu_c, alu_s}     = {1'b0, alu_a} + {1'b0, alu_b ^ {4{alu_k}}} + {4'b0000, alu_k};
  assign {c_alu_c, c_alu_s} = {1'b0, c_alu_a} + {1'b0, c_alu_b ^ {4{c_alu_k}}} + {4'b0000, c_alu_k};

  addsub_share_scheduler #(.NIB(4), .SKIP_INC(1'b1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .op_a0(op_a0), .op_b0(op_b0), .op_k0(op_k0),
    .op_a1(op_a1), .op_b1(op_b1), .op_k1(op_k1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .res_c(res_c), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_k(alu_k), .alu_s(alu_s), .alu_c(alu_c)
  );

  addsub_share_scheduler #(.NIB(4), .SKIP_INC(1'b0)) dut_c (
    .clk(clk), .rst(rst), .req0(c_req0), .req1(c_req1),
    .op_a0(c_op_a0), .op_b0(c_op_b0), .op_k0(c_op_k0),
    .op_a1(c_op_a1), .op_b1(c_op_b1), .op_k1(c_op_k1),
    .gnt0(c_gnt0), .gnt1(c_gnt1), .done0(c_done0), .done1(c_done1),
    .res(c_res), .res_c(c_res_c), .busy(c_busy),
    .alu_a(c_alu_a), .alu_b(c_alu_b), .alu_k(c_alu_k), .alu_s(c_alu_s), .alu_c(c_alu_c)
  );

  addsub_share_scheduler_checker #(.NIB(4)) chk (
    .clk(clk), .rst(rst), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_k(alu_k)
  );

  addsub_share_scheduler_checker #(.NIB(4)) chk_c (
    .clk(clk), .rst(rst), .gnt0(c_gnt0), .gnt1(c_gnt1), .done0(c_done0), .done1(c_done1),
    .busy(c_busy), .alu_a(c_alu_a), .alu_b(c_alu_b), .alu_k(c_alu_k)
  );

  // Reference: 9-bit sum; for subtraction A + ~B + 1, carry = no borrow
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic k);
    logic [8:0] r;
    if (k) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  // Expected latency: carry pass only when the low nibble produces a carry
  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b, input logic k);
    logic c0;
    if (k) c0 = (a[3:0] >= b[3:0]);
    else   c0 = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
    return c0 ? 4 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input bit sel, input bit id, input logic rq,
                       input logic [7:0] a, input logic [7:0] b, input logic k);
    if (!sel && !id) begin
      req0 = rq; op_a0 = a; op_b0 = b; op_k0 = k;
    end else if (!sel && id) begin
      req1 = rq; op_a1 = a; op_b1 = b; op_k1 = k;
    end else if (sel && !id) begin
      c_req0 = rq; c_op_a0 = a; c_op_b0 = b; c_op_k0 = k;
    end else begin
      c_req1 = rq; c_op_a1 = a; c_op_b1 = b; c_op_k1 = k;
    end
  endtask

  // Issue one request and collect what the DUT reports (no checking here)
  task automatic do_op(input bit sel, input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic k, output bit gnt_ok, output bit done_ok, output int lat,
                       output logic [7:0] r, output logic rc);
    logic g, d;
    gnt_ok = 1'b0; done_ok = 1'b0; lat = 0; r = 8'h00; rc = 1'b0;
    drive(sel, id, 1'b1, a, b, k);
    for (int i = 0; i < 8; i++) begin
      if (!gnt_ok) begin
        tick();
        g = sel ? (id ? c_gnt1 : c_gnt0) : (id ? gnt1 : gnt0);
        if (g) gnt_ok = 1'b1;
      end
    end
    drive(sel, id, 1'b0, a, b, k);
    for (int i = 1; i <= 10; i++) begin
      if (!done_ok && gnt_ok) begin
        tick();
        d = sel ? (id ? c_done1 : c_done0) : (id ? done1 : done0);
        if (d) begin
          done_ok = 1'b1;
          lat = i;
          r  = sel ? c_res : res;
          rc = sel ? c_res_c : res_c;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [22:0] v, vc;
    apply_reset();
    v  = {gnt0, gnt1, done0, done1, busy, res_c, res, alu_a, alu_b, alu_k};
    vc = {c_gnt0, c_gnt1, c_done0, c_done1, c_busy, c_res_c, c_res, c_alu_a, c_alu_b, c_alu_k};
    checks++;
    if (v !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 000000", v);
    end
    checks++;
    if (vc !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs_const: got %h expected 000000", vc);
    end
  endtask

  task automatic test_single(input string name, input bit id, input logic [7:0] a,
                             input logic [7:0] b, input logic k, input logic [7:0] er,
                             input logic erc, input int elat);
    bit g, d; int lat; logic [7:0] r; logic rc;
    do_op(1'b0, id, a, b, k, g, d, lat, r, rc);
    checks++;
    if (!g || !d) begin
      errors++;
      $display("FAIL %s_handshake: gnt=%0b done=%0b expected 1 1", name, g, d);
    end
    checks++;
    if (r !== er || rc !== erc) begin
      errors++;
      $display("FAIL %s_result: res=%h c=%b expected res=%h c=%b", name, r, rc, er, erc);
    end
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, elat);
    end
  endtask

  task automatic test_busy();
    logic [11:0] v;
    bit d; int lat;
    drive(1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
    tick();
    v = {gnt0, gnt1, busy, done0, alu_a, alu_b};  // gnt cycle, low pass drives
    checks++;
    if (v !== {4'b1000, 4'h2, 4'h4} || alu_k !== 1'b0) begin
      errors++; $display("FAIL busy_c1: got %h k=%b expected 824 k=0", v, alu_k);
    end
    op_a0 = 8'h01;   // change after gnt; req0 stays high through busy
    tick();
    v = {gnt0, gnt1, busy, done0, alu_a, alu_b};
    checks++;
    if (v !== {4'b0010, 4'h1, 4'h3}) begin
      errors++; $display("FAIL busy_c2: got %h expected 213", v);
    end
    tick();
    v = {gnt0, gnt1, busy, done0, alu_a, alu_b};
    checks++;
    if (v !== {4'b0010, 4'h0, 4'h0}) begin
      errors++; $display("FAIL busy_c3: got %h expected 200", v);
    end
    tick();
    checks++;
    if ({gnt0, busy, done0} !== 3'b011 || res !== 8'h46 || res_c !== 1'b0) begin
      errors++;
      $display("FAIL busy_c4: g/b/d=%b res=%h c=%b expected 011 46 0", {gnt0, busy, done0}, res, res_c);
    end
    tick();  // req0 still high in IDLE: new request with the new operands
    v = {gnt0, gnt1, busy, done0, alu_a, alu_b};
    checks++;
    if (v !== {4'b1000, 4'h1, 4'h4}) begin
      errors++; $display("FAIL busy_rereq: got %h expected 814", v);
    end
    req0 = 1'b0;
    d = 1'b0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (!d) begin
        tick();
        if (done0) begin d = 1'b1; lat = i; end
      end
    end
    checks++;
    if (!d || lat != 3 || res !== 8'h35 || res_c !== 1'b0) begin
      errors++;
      $display("FAIL busy_rereq_result: done=%0b lat=%0d res=%h expected 1 3 35", d, lat, res);
    end
  endtask

  task automatic test_tie();
    bit d, gseen;
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 8'h50, 8'h20, 1'b1);
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL tie_first: gnt0/1=%b expected 10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    gseen = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (gnt1 || gnt0) gseen = 1'b1;
    end
    checks++;
    if (gseen || !done0 || res !== 8'h46) begin
      errors++;
      $display("FAIL tie_busy: gnt_seen=%0b done0=%b res=%h expected 0 1 46", gseen, done0, res);
    end
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      errors++; $display("FAIL tie_second: gnt0/1=%b expected 01", {gnt0, gnt1});
    end
    req1 = 1'b0;
    d = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!d) begin
        tick();
        if (done1) d = 1'b1;
      end
    end
    checks++;
    if (!d || res !== 8'h30 || res_c !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL tie_second_result: done1=%0b res=%h c=%b expected 1 30 1", d, res, res_c);
    end
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL tie_again: gnt0/1=%b expected 10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_mid();
    logic [22:0] v;
    bit dseen, d;
    int lat;
    drive(1'b0, 1'b0, 1'b1, 8'h3C, 8'h0F, 1'b0);
    tick();
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL rstmid_gnt: gnt0=%b expected 1", gnt0);
    end
    req0 = 1'b0;
    tick();              // high pass in progress
    rst = 1'b1;
    tick();
    v = {gnt0, gnt1, done0, done1, busy, res_c, res, alu_a, alu_b, alu_k};
    checks++;
    if (v !== 23'd0) begin
      errors++; $display("FAIL rstmid_outputs: got %h expected 000000", v);
    end
    rst = 1'b0;
    dseen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done0 || done1 || busy) dseen = 1'b1;
    end
    checks++;
    if (dseen) begin
      errors++; $display("FAIL rstmid_no_done: activity=%0b expected 0", dseen);
    end
    // pointer back to 1: the tie goes to requester 0 again
    drive(1'b0, 1'b0, 1'b1, 8'h3C, 8'h0F, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 8'h50, 8'h20, 1'b1);
    tick();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL rstmid_ptr: gnt0/1=%b expected 10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    d = 1'b0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (!d) begin
        tick();
        if (done0) begin d = 1'b1; lat = i; end
      end
    end
    checks++;
    if (!d || lat != 4 || res !== 8'h4B || res_c !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_rereq: done=%0b lat=%0d res=%h c=%b expected 1 4 4b 0", d, lat, res, res_c);
    end
  endtask

  task automatic test_sweep(input bit sel, input int n_rand);
    logic [7:0] corner [8];
    logic [7:0] a, b, r;
    logic k, rc;
    logic [8:0] e;
    bit g, d;
    int lat, elat, n;
    corner = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h7F, 8'h80, 8'hF0, 8'hFF};
    n = 0;
    for (int t = 0; t < 128 + n_rand; t++) begin
      if (t < 128) begin
        a = corner[t % 8];
        b = corner[(t / 8) % 8];
        k = (t >= 64);
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        k = 1'($urandom_range(0, 1));
      end
      do_op(sel, n[0], a, b, k, g, d, lat, r, rc);
      e    = model(a, b, k);
      elat = sel ? 4 : exp_lat(a, b, k);
      checks++;
      if (!g || !d || r !== e[7:0] || rc !== e[8] || lat != elat) begin
        errors++;
        $display("FAIL sweep%0d: %h %s %h req%0d got res=%h c=%b lat=%0d expected res=%h c=%b lat=%0d",
                 sel, a, k ? "-" : "+", b, n[0], r, rc, lat, e[7:0], e[8], elat);
      end
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op_a0 = 8'h00; op_b0 = 8'h00; op_k0 = 1'b0;
    op_a1 = 8'h00; op_b1 = 8'h00; op_k1 = 1'b0;
    c_req0 = 1'b0; c_req1 = 1'b0; c_op_a0 = 8'h00; c_op_b0 = 8'h00; c_op_k0 = 1'b0;
    c_op_a1 = 8'h00; c_op_b1 = 8'h00; c_op_k1 = 1'b0;
    test_reset();
    test_single("add_basic", 1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);
    test_single("add_inc",   1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 4);
    test_single("sub",       1'b1, 8'h50, 8'h20, 1'b1, 8'h30, 1'b1, 4);
    test_single("wrap",      1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4);
    test_busy();
    test_tie();
    test_reset_mid();
    test_sweep(1'b0, 600);
    test_sweep(1'b1, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
